// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {pc, instr} with flush/trap kill.
// Latency: 1 cycle from push edge to out_*; no empty bypass, outputs come from registers only.
// Backpressure: in_ready = not full (independent of out_ready); kill discards queue and same-cycle push/pop.
module if_id_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    input  logic                       flush,
    input  logic                       csr_flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic w_kill;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Occupancy alone decides full/empty; pointers are equal in both cases.
    assign w_kill    = flush | csr_flush;
    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;
    assign w_push    = in_valid && !w_full && !w_kill;
    assign w_pop     = !w_empty && out_ready && !w_kill;

    // Entry storage: written at the tail on an accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]    <= in_pc;
            r_instr_mem[r_tail] <= in_instr;
        end
    end

    // Head/tail pointers wrap naturally modulo DEPTH (power of two); kill rewinds both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (w_kill) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
        end
    end

    // Occupancy counter: push and pop together leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_kill) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation: storage when valid, otherwise pc 0 and a NOP.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (!w_empty) begin
            out_pc    = r_pc_mem[r_head];
            out_instr = r_instr_mem[r_head];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic.
// A queue-based reference model tracks accepted entries; a negedge monitor compares every cycle.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic        csr_flush;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t exp_q[$];

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .csr_flush (csr_flush),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of accepted entries, updated at each edge.
    always @(posedge clk or negedge rst) begin
        bit do_pop;
        bit do_push;
        if (!rst) begin
            exp_q.delete();
        end else if (flush || csr_flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (exp_q.size() > 0) && out_ready;
            do_push = in_valid && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{pc: in_pc, instr: in_instr});
        end
    end

    // Monitor: compare everything the DUT presents against the model head.
    always @(negedge clk) begin
        int n;
        n = exp_q.size();
        chk("count", 64'(count), 64'(n));
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        if (n != 0) begin
            chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        end else begin
            chk("idle_pc", 64'(out_pc), 64'(0));
            chk("idle_instr", 64'(out_instr), 64'(NOP));
        end
    end

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl, input logic cfl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        csr_flush = cfl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0; csr_flush = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(NOP));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Two pushes held, head visible one cycle after the first push.
        drive(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        chk("first_push_pc", 64'(out_pc), 64'h100);
        chk("first_push_instr", 64'(out_instr), 64'h0050_0093);
        drive(1'b1, 32'h104, 32'h00A0_0113, 1'b0, 1'b0, 1'b0);
        chk("two_count", 64'(count), 64'(2));
        chk("two_head_pc", 64'(out_pc), 64'h100);
        drain();

        // Fill to DEPTH, refuse the fifth push, then free one slot.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h2F0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("full_refuse_count", 64'(count), 64'(DEPTH));
        drive(1'b1, 32'h2F0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        chk("full_pop_count", 64'(count), 64'(DEPTH - 1));
        chk("full_pop_in_ready", 64'(in_ready), 64'(1));
        chk("full_pop_head", 64'(out_pc), 64'h204);
        drain();

        // Steady stream: occupancy stays at one while pointers wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_count", 64'(count), 64'(1));
            chk("stream_pc", 64'(out_pc), 64'(32'h300 + 32'(4 * i)));
        end
        drain();

        // Flush with simultaneous push and pop discards everything.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h4F0, 32'h3FFF, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_out_instr", 64'(out_instr), 64'h13);

        // Trap kill behaves the same.
        for (int i = 0; i < 2; i++)
            drive(1'b1, 32'h500 + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h5F0, 32'h4FFF, 1'b0, 1'b0, 1'b1);
        chk("csr_flush_count", 64'(count), 64'(0));

        // Asynchronous reset pulse between edges with entries held.
        for (int i = 0; i < 2; i++)
            drive(1'b1, 32'h600 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_count", 64'(count), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h700, 32'h6000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", 64'(count), 64'(1));
        chk("post_rst_pc", 64'(out_pc), 64'h700);
        drain();

        // Popping an empty queue is ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("empty_pop_count", 64'(count), 64'(0));
            chk("empty_pop_pc", 64'(out_pc), 64'(0));
        end

        // Random traffic with occasional kills and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 60) == 0));
            if ($urandom_range(0, 250) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        drain();

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of the PC and instruction fields.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, the value driven on out_instr when no entry is valid.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port in_valid, input, 1 bit, asserted when IF presents a fetched entry.
REQ-007 The block SHALL have port in_ready, output, 1 bit, asserted when the queue accepts an entry this cycle.
REQ-008 The block SHALL have port in_pc, input, XLEN bits, the PC of the fetched instruction.
REQ-009 The block SHALL have port in_instr, input, XLEN bits, the fetched instruction word.
REQ-010 The block SHALL have port out_valid, output, 1 bit, asserted when the head entry is presented to ID.
REQ-011 The block SHALL have port out_ready, input, 1 bit, asserted when ID consumes the head entry.
REQ-012 The block SHALL have port out_pc, output, XLEN bits, the PC of the head entry.
REQ-013 The block SHALL have port out_instr, output, XLEN bits, the instruction of the head entry.
REQ-014 The block SHALL have port flush, input, 1 bit, the branch/jump redirect kill.
REQ-015 The block SHALL have port csr_flush, input, 1 bit, the trap/CSR redirect kill; it has the same effect as flush.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH+1) bits, the number of valid entries.

Function
REQ-017 Push: the block SHALL store {in_pc, in_instr} at the tail when in_valid && in_ready && !kill, where kill = flush | csr_flush.
REQ-018 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend combinationally on out_ready, so a full queue with a simultaneous pop still refuses the push.
REQ-019 Pop: the head entry SHALL be removed when out_valid && out_ready && !kill.
REQ-020 out_valid SHALL equal (count != 0); out_pc and out_instr SHALL be driven from registered storage only, with no input-to-output combinational path.
REQ-021 Latency: an entry pushed at edge N SHALL be visible on out_* after edge N, with a minimum latency of 1 cycle and no bypass when empty.
REQ-022 When out_valid is 0, out_pc SHALL be 0 and out_instr SHALL be NOP_INSTR.
REQ-023 Simultaneous push and pop (count between 1 and DEPTH-1) SHALL leave count unchanged and preserve FIFO order.
REQ-024 A pop when empty SHALL be ignored; a push when full SHALL be ignored, and the producer must hold in_valid until it is accepted.
REQ-025 Kill SHALL clear all entries synchronously: count=0 and out_valid=0 after the edge; any push or pop in the same cycle SHALL be discarded.
REQ-026 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be decided by count, never by pointer equality alone.
REQ-027 count SHALL never exceed DEPTH and never underflow below 0.
REQ-028 Entry storage need not be cleared on kill; only pointers and count are reset.

Reset
REQ-029 While rst=0, regardless of clk, the block SHALL force head=0, tail=0 and count=0, giving out_valid=0, out_pc=0, out_instr=NOP_INSTR and in_ready=1.
REQ-030 Reset deassertion SHALL be synchronous to clk by the system; the first push SHALL be accepted on the first rising edge with rst=1.
REQ-031 Reset asserted mid-transfer SHALL discard all entries immediately, and no partial entry SHALL appear afterward.

Verification
REQ-032 Scenario: push pc=0x100 instr=0x00500093, then pc=0x104 instr=0x00A00113, with out_ready=0 -> count=2; out_pc=0x100 one cycle after the first push.
REQ-033 Scenario: push 4 entries (DEPTH=4) with out_ready=0 -> in_ready=0 and a 5th push is refused; pop one -> in_ready=1 the next cycle.
REQ-034 Scenario: steady stream with in_valid=1 and out_ready=1 for 10 cycles -> count stays 1, outputs emerge in order, and pointers wrap past 3 to 0.
REQ-035 Scenario: 3 entries held, then flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013, and the pushed entry is lost.
REQ-036 Scenario: 2 entries held, then rst=0 pulsed between clock edges -> out_valid=0 immediately, without waiting for a clock edge; after release a push appears with count=1.
REQ-037 Scenario: empty queue, out_ready=1 for 3 cycles with no push -> count stays 0 and out_pc stays 0.
